// File: rtl/nco_ctrl_pkg.sv
// nco_ctrl_pkg: shared encodings for the data-separator NCO loop controller.
//   - rate_sel encodings and nominal NCO frequency words per data rate
//   - nominal_fw(): maps rate_sel to its nominal frequency word
//   - loop_state encodings driven on nco_loop_ctrl.loop_state
package nco_ctrl_pkg;

  typedef enum logic [1:0] {
    RATE_250K = 2'b00,
    RATE_300K = 2'b01,
    RATE_500K = 2'b10,
    RATE_1M   = 2'b11
  } rate_e;

  localparam logic [31:0] FW_250K = 32'h0051EB85;
  localparam logic [31:0] FW_300K = 32'h00624DD3;
  localparam logic [31:0] FW_500K = 32'h00A3D70A;
  localparam logic [31:0] FW_1M   = 32'h0147AE14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } loop_state_e;

  function automatic logic [31:0] nominal_fw(input logic [1:0] rate);
    logic [31:0] fw;
    fw = FW_250K;
    case (rate)
      RATE_250K: fw = FW_250K;
      RATE_300K: fw = FW_300K;
      RATE_500K: fw = FW_500K;
      RATE_1M:   fw = FW_1M;
      default:   fw = FW_250K;
    endcase
    return fw;
  endfunction

endpackage

// File: rtl/dpll_loop_filter.sv
// dpll_loop_filter: PI filter for the NCO loop.
//   clk, reset       : clock and synchronous active-high reset
//   clear            : zero the integrator (loop (re)start or disable)
//   update           : accumulate err into the integrator this cycle
//   acq              : use the higher acquisition proportional gain
//   err[15:0]        : signed phase error of the edge being processed
//   nominal[31:0]    : nominal frequency word for the current rate
//   phase_adj_next   : -(err >>> kp), to be registered by the parent
//   freq_word_next   : nominal - (integ >>> KI_SHIFT), clamped; reflects
//                      the integrator value including this edge's err
module dpll_loop_filter #(
  parameter int KP_SHIFT     = 4,
  parameter int KI_SHIFT     = 10,
  parameter int FW_DEV_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        update,
  input  logic        acq,
  input  logic [15:0] err,
  input  logic [31:0] nominal,
  output logic [15:0] phase_adj_next,
  output logic [31:0] freq_word_next
);

  localparam logic signed [32:0] SAT_POS = 33'sh0_7FFF_FFFF;
  localparam logic signed [32:0] SAT_NEG = -33'sh0_7FFF_FFFF;

  logic signed [31:0] integ_q;
  logic signed [31:0] integ_sat;
  logic signed [31:0] integ_scaled;
  logic signed [32:0] integ_sum;
  logic signed [15:0] err_s;
  logic signed [15:0] err_shifted;
  logic        [31:0] fw_dev;
  logic signed [33:0] fw_raw;
  logic signed [33:0] fw_lo;
  logic signed [33:0] fw_hi;

  assign err_s          = $signed(err);
  assign err_shifted    = acq ? (err_s >>> (KP_SHIFT - 2)) : (err_s >>> KP_SHIFT);
  assign phase_adj_next = -err_shifted;

  // One guard bit so overflow is visible before saturating; never wraps.
  always_comb begin
    integ_sum = {integ_q[31], integ_q} + {{17{err[15]}}, err};
    if (integ_sum > SAT_POS) begin
      integ_sat = 32'sh7FFF_FFFF;
    end else if (integ_sum < SAT_NEG) begin
      integ_sat = 32'sh8000_0001;
    end else begin
      integ_sat = integ_sum[31:0];
    end
  end

  assign integ_scaled = integ_sat >>> KI_SHIFT;
  assign fw_dev       = nominal >> FW_DEV_SHIFT;

  always_comb begin
    fw_raw = $signed({2'b00, nominal}) - $signed({{2{integ_scaled[31]}}, integ_scaled});
    fw_lo  = $signed({2'b00, nominal - fw_dev});
    fw_hi  = $signed({2'b00, nominal + fw_dev});
    if (fw_raw < fw_lo) begin
      freq_word_next = fw_lo[31:0];
    end else if (fw_raw > fw_hi) begin
      freq_word_next = fw_hi[31:0];
    end else begin
      freq_word_next = fw_raw[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      integ_q <= '0;
    end else if (update) begin
      integ_q <= integ_sat;
    end
  end

endmodule

// File: rtl/nco_loop_ctrl.sv
// nco_loop_ctrl: closed-loop PI controller for the data-separator NCO.
// Samples the NCO phase on each flux edge, runs the PI filter and sequences
// acquisition / tracking / lock detection.
// Build option: define NCO_LOOP_STATS_EN to generate the edge_count and
// max_err statistics; otherwise both ports are tied to zero.
//   clk, reset           : clock, synchronous active-high reset
//   enable               : run the loop
//   rate_sel[1:0]        : data rate, selects the nominal frequency word
//   flux_edge            : one-cycle flux transition pulse
//   phase_accum[31:0]    : NCO phase accumulator, error = phase_accum[31:16]
//   nco_enable           : NCO enable
//   freq_word[31:0]      : NCO frequency word
//   phase_adj[15:0]      : signed phase correction, qualified by phase_adj_valid
//   locked, loop_state   : lock flag and current state
//   edge_count, max_err  : statistics
// Pipeline: edge sampled at N, error registered at N+1, outputs and state at N+2.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | loop off, NCO disabled, freq_word held at nominal
// ACQUIRE  | NCO running, proportional gain raised, for ACQ_EDGES edges
// TRACK    | normal gain, counting consecutive in-window edges to lock
// LOCKED   | locked high, counting consecutive out-of-window edges
module nco_loop_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int          KP_SHIFT     = 4,
  parameter int          KI_SHIFT     = 10,
  parameter int          FW_DEV_SHIFT = 4,
  parameter int          ACQ_EDGES    = 8,
  parameter int          LOCK_COUNT   = 16,
  parameter logic [15:0] LOCK_THRESH  = 16'h1000,
  parameter int          UNLOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  rate_sel,
  input  logic        flux_edge,
  input  logic [31:0] phase_accum,
  output logic        nco_enable,
  output logic [31:0] freq_word,
  output logic [15:0] phase_adj,
  output logic        phase_adj_valid,
  output logic        locked,
  output logic [1:0]  loop_state,
  output logic [15:0] edge_count,
  output logic [15:0] max_err
);

  localparam logic [15:0] ACQ_LOAD    = 16'(ACQ_EDGES);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_COUNT - 1);
  localparam logic [15:0] UNLOCK_LAST = 16'(UNLOCK_COUNT - 1);

  loop_state_e state_q, state_d;
  logic [1:0]  rate_q;
  logic [31:0] nom_fw;
  logic        rate_chg, proc_ok, acq_start, edge_ok;
  logic        e_vld_q;
  logic [15:0] e_q, e_abs;
  logic        in_thr;
  logic [15:0] acq_left, lock_cnt, unlock_cnt;
  logic [15:0] padj_next;
  logic [31:0] fw_next;
  logic        unused_lsbs;

  assign unused_lsbs = ^phase_accum[15:0];
  assign nom_fw      = nominal_fw(rate_sel);

  // A rate change while running restarts acquisition and discards both the
  // edge arriving this cycle and the one already in the pipeline.
  assign rate_chg  = (state_q != ST_IDLE) && (rate_sel != rate_q);
  assign proc_ok   = enable && !rate_chg && (state_q != ST_IDLE);
  assign acq_start = enable && ((state_q == ST_IDLE) || rate_chg);
  assign edge_ok   = e_vld_q && proc_ok;

  // |-32768| = 32768 fits in 16 unsigned bits.
  assign e_abs  = e_q[15] ? (~e_q + 16'd1) : e_q;
  assign in_thr = (e_abs < LOCK_THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_IDLE) || rate_chg) begin
      state_d = ST_ACQUIRE;
    end else if (edge_ok) begin
      case (state_q)
        ST_ACQUIRE: if (acq_left <= 16'd1) state_d = ST_TRACK;
        ST_TRACK:   if (in_thr && (lock_cnt == LOCK_LAST)) state_d = ST_LOCKED;
        ST_LOCKED:  if (!in_thr && (unlock_cnt == UNLOCK_LAST)) state_d = ST_TRACK;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    nco_enable = (state_q != ST_IDLE);
    locked     = (state_q == ST_LOCKED);
    loop_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acq_left   <= '0;
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else if (acq_start) begin
      acq_left   <= ACQ_LOAD;
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else if (edge_ok) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (acq_left != 16'd0) acq_left <= acq_left - 16'd1;
        end
        ST_TRACK: begin
          lock_cnt <= (in_thr && (lock_cnt != LOCK_LAST)) ? lock_cnt + 16'd1 : 16'd0;
        end
        ST_LOCKED: begin
          unlock_cnt <= (!in_thr && (unlock_cnt != UNLOCK_LAST)) ? unlock_cnt + 16'd1 : 16'd0;
          lock_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q  <= rate_sel;
      e_vld_q <= 1'b0;
      e_q     <= '0;
    end else begin
      rate_q  <= rate_sel;
      e_vld_q <= flux_edge && proc_ok;
      e_q     <= phase_accum[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_adj       <= '0;
      phase_adj_valid <= 1'b0;
      freq_word       <= nom_fw;
    end else if (!proc_ok) begin
      phase_adj_valid <= 1'b0;
      freq_word       <= nom_fw;
    end else begin
      phase_adj_valid <= e_vld_q;
      if (e_vld_q) begin
        phase_adj <= padj_next;
        freq_word <= fw_next;
      end
    end
  end

  dpll_loop_filter #(
    .KP_SHIFT     (KP_SHIFT),
    .KI_SHIFT     (KI_SHIFT),
    .FW_DEV_SHIFT (FW_DEV_SHIFT)
  ) u_filter (
    .clk            (clk),
    .reset          (reset),
    .clear          (acq_start || !enable),
    .update         (edge_ok),
    .acq            (state_q == ST_ACQUIRE),
    .err            (e_q),
    .nominal        (nom_fw),
    .phase_adj_next (padj_next),
    .freq_word_next (fw_next)
  );

`ifdef NCO_LOOP_STATS_EN
  logic [15:0] edge_cnt_q, max_err_q, e_abs_sat;

  assign e_abs_sat = e_abs[15] ? 16'h7FFF : e_abs;

  always_ff @(posedge clk) begin
    if (reset || acq_start) begin
      edge_cnt_q <= '0;
      max_err_q  <= '0;
    end else if (edge_ok) begin
      if (edge_cnt_q != 16'hFFFF) edge_cnt_q <= edge_cnt_q + 16'd1;
      if (e_abs_sat > max_err_q) max_err_q <= e_abs_sat;
    end
  end

  assign edge_count = edge_cnt_q;
  assign max_err    = max_err_q;
`else
  assign edge_count = '0;
  assign max_err    = '0;
`endif

endmodule

// File: tb/tb_nco_loop_ctrl.sv
module tb_nco_loop_ctrl;

  localparam int CLAMP_EDGES = 21500;

  logic        clk = 1'b0;
  logic        reset, enable, flux_edge;
  logic [1:0]  rate_sel;
  logic [31:0] phase_accum;
  logic        nco_enable, phase_adj_valid, locked;
  logic [31:0] freq_word;
  logic [15:0] phase_adj, edge_count, max_err;
  logic [1:0]  loop_state;

  typedef struct packed {
    logic [15:0] padj;
    logic [31:0] fw;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_x;
  int     errors = 0;
  int     checks = 0;
  longint m_integ, m_nom;
  int     m_edges;

  nco_loop_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .rate_sel        (rate_sel),
    .flux_edge       (flux_edge),
    .phase_accum     (phase_accum),
    .nco_enable      (nco_enable),
    .freq_word       (freq_word),
    .phase_adj       (phase_adj),
    .phase_adj_valid (phase_adj_valid),
    .locked          (locked),
    .loop_state      (loop_state),
    .edge_count      (edge_count),
    .max_err         (max_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input logic [31:0] nom);
    m_integ = 0;
    m_edges = 0;
    m_nom   = longint'(nom);
  endtask

  // Reference PI loop in 64-bit arithmetic; pushes the expected outputs.
  task automatic model_push(input logic [15:0] e);
    longint es, fw, lo, hi;
    int     kp;
    exp_t   x;
    es = longint'($signed(e));
    kp = (m_edges < 8) ? 2 : 4;
    x.padj = 16'(-(es >>> kp));
    m_integ = m_integ + es;
    if (m_integ > 64'sd2147483647)  m_integ = 64'sd2147483647;
    if (m_integ < -64'sd2147483647) m_integ = -64'sd2147483647;
    fw = m_nom - (m_integ >>> 10);
    lo = m_nom - (m_nom >> 4);
    hi = m_nom + (m_nom >> 4);
    if (fw < lo) fw = lo;
    if (fw > hi) fw = hi;
    x.fw = 32'(fw);
    m_edges++;
    sb.push_back(x);
  endtask

  // One edge, then one idle cycle: returns with this edge's outputs visible.
  task automatic send_edge(input logic [15:0] e, input bit push);
    flux_edge   = 1'b1;
    phase_accum = {e, 16'hA5A5};
    if (push) model_push(e);
    tick();
    flux_edge = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (phase_adj_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: phase_adj_valid=1 phase_adj=%h with no edge pending", phase_adj);
      end else begin
        mon_x = sb.pop_front();
        if (phase_adj !== mon_x.padj || freq_word !== mon_x.fw) begin
          errors++;
          $display("FAIL scoreboard: got phase_adj=%h freq_word=%h expected phase_adj=%h freq_word=%h",
                   phase_adj, freq_word, mon_x.padj, mon_x.fw);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rate_sel = 2'b10; flux_edge = 1'b0; phase_accum = '0;
    tick(); tick();
    checks++;
    if (loop_state !== 2'd0 || nco_enable !== 1'b0 || locked !== 1'b0 || phase_adj_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got state=%0d nco_en=%b locked=%b valid=%b expected 0 0 0 0",
               loop_state, nco_enable, locked, phase_adj_valid);
    end
    checks++;
    if (freq_word !== 32'h00A3D70A || phase_adj !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got fw=%h padj=%h expected 00a3d70a 0000", freq_word, phase_adj);
    end
    checks++;
    if (edge_count !== 16'h0 || max_err !== 16'h0) begin
      errors++;
      $display("FAIL reset_stats: got edge_count=%h max_err=%h expected 0 0", edge_count, max_err);
    end
  endtask

  task automatic test_enable();
    reset = 1'b0;
    tick();
    checks++;
    if (loop_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_hold: got state=%0d expected 0", loop_state);
    end
    enable = 1'b1;
    model_clear(32'h00A3D70A);
    tick();
    checks++;
    if (loop_state !== 2'd1 || nco_enable !== 1'b1 || freq_word !== 32'h00A3D70A) begin
      errors++;
      $display("FAIL enable_acq: got state=%0d nco_en=%b fw=%h expected 1 1 00a3d70a",
               loop_state, nco_enable, freq_word);
    end
  endtask

  task automatic test_track_edge();
    for (int i = 0; i < 8; i++) send_edge(16'h0000, 1'b1);
    checks++;
    if (loop_state !== 2'd2) begin
      errors++;
      $display("FAIL acq_to_track: got state=%0d expected 2", loop_state);
    end
    send_edge(16'h1000, 1'b1);
    checks++;
    if (phase_adj_valid !== 1'b1 || phase_adj !== 16'hFF00 || freq_word !== 32'h00A3D706) begin
      errors++;
      $display("FAIL track_edge: got valid=%b padj=%h fw=%h expected 1 ff00 00a3d706",
               phase_adj_valid, phase_adj, freq_word);
    end
    tick();
    checks++;
    if (phase_adj_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: got valid=%b expected 0", phase_adj_valid);
    end
  endtask

  task automatic test_rate_change();
    flux_edge = 1'b1; phase_accum = 32'h0400_0000;
    tick();
    rate_sel = 2'b00;
    model_clear(32'h0051EB85);
    tick();
    flux_edge = 1'b0;
    checks++;
    if (loop_state !== 2'd1 || freq_word !== 32'h0051EB85 || phase_adj_valid !== 1'b0) begin
      errors++;
      $display("FAIL rate_change: got state=%0d fw=%h valid=%b expected 1 0051eb85 0",
               loop_state, freq_word, phase_adj_valid);
    end
    tick();
    checks++;
    if (phase_adj_valid !== 1'b0 || loop_state !== 2'd1) begin
      errors++;
      $display("FAIL rate_discard: got valid=%b state=%0d expected 0 1", phase_adj_valid, loop_state);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 23; i++) send_edge(16'h0100, 1'b1);
    checks++;
    if (locked !== 1'b0 || loop_state !== 2'd2) begin
      errors++;
      $display("FAIL lock_early: got locked=%b state=%0d expected 0 2", locked, loop_state);
    end
    send_edge(16'h0100, 1'b1);
    checks++;
    if (locked !== 1'b1 || loop_state !== 2'd3) begin
      errors++;
      $display("FAIL lock_rise: got locked=%b state=%0d expected 1 3", locked, loop_state);
    end
`ifdef NCO_LOOP_STATS_EN
    checks++;
    if (edge_count !== 16'd24 || max_err !== 16'h0100) begin
      errors++;
      $display("FAIL lock_stats: got edge_count=%0d max_err=%h expected 24 0100", edge_count, max_err);
    end
`endif
    for (int i = 0; i < 3; i++) send_edge(16'h2000, 1'b1);
    checks++;
    if (locked !== 1'b1 || loop_state !== 2'd3) begin
      errors++;
      $display("FAIL unlock_early: got locked=%b state=%0d expected 1 3", locked, loop_state);
    end
    send_edge(16'h2000, 1'b1);
    checks++;
    if (locked !== 1'b0 || loop_state !== 2'd2) begin
      errors++;
      $display("FAIL unlock: got locked=%b state=%0d expected 0 2", locked, loop_state);
    end
    for (int i = 0; i < 16; i++) send_edge(16'h0100, 1'b1);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: got locked=%b expected 1", locked);
    end
  endtask

  task automatic test_disable();
    flux_edge = 1'b1; phase_accum = 32'h2000_0000;
    tick();
    flux_edge = 1'b0;
    enable = 1'b0;
    tick();
    checks++;
    if (loop_state !== 2'd0 || locked !== 1'b0 || nco_enable !== 1'b0 || phase_adj_valid !== 1'b0 ||
        freq_word !== 32'h0051EB85) begin
      errors++;
      $display("FAIL disable: got state=%0d locked=%b nco_en=%b valid=%b fw=%h expected 0 0 0 0 0051eb85",
               loop_state, locked, nco_enable, phase_adj_valid, freq_word);
    end
`ifdef NCO_LOOP_STATS_EN
    checks++;
    if (edge_count !== 16'd44) begin
      errors++;
      $display("FAIL disable_stats: got edge_count=%0d expected 44", edge_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    rate_sel = 2'b10;
    enable = 1'b1;
    model_clear(32'h00A3D70A);
    tick();
    send_edge(16'h0100, 1'b1);
    send_edge(16'hFF00, 1'b1);
    flux_edge = 1'b1; phase_accum = 32'h0100_0000;
    tick();
    flux_edge = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (loop_state !== 2'd0 || locked !== 1'b0 || nco_enable !== 1'b0 || phase_adj_valid !== 1'b0 ||
        phase_adj !== 16'h0 || freq_word !== 32'h00A3D70A || edge_count !== 16'h0 || max_err !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got state=%0d locked=%b nco_en=%b valid=%b padj=%h fw=%h ec=%h me=%h expected all reset values",
               loop_state, locked, nco_enable, phase_adj_valid, phase_adj, freq_word, edge_count, max_err);
    end
    reset = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_clamp(input logic [15:0] e, input logic [31:0] bound, input bit low_side);
    longint extreme;
    rate_sel = 2'b10;
    model_clear(32'h00A3D70A);
    enable = 1'b1;
    tick();
    extreme = low_side ? 64'sh0FFFFFFFF : 64'sh0;
    flux_edge = 1'b1;
    phase_accum = {e, 16'h0F0F};
    for (int i = 0; i < CLAMP_EDGES; i++) begin
      model_push(e);
      tick();
      if (low_side && longint'(freq_word) < extreme) extreme = longint'(freq_word);
      if (!low_side && longint'(freq_word) > extreme) extreme = longint'(freq_word);
    end
    flux_edge = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (freq_word !== bound) begin
      errors++;
      $display("FAIL clamp_final: got fw=%h expected %h", freq_word, bound);
    end
    checks++;
    if (extreme !== longint'(bound)) begin
      errors++;
      $display("FAIL clamp_extreme: got peak fw=%h expected %h", extreme, bound);
    end
`ifdef NCO_LOOP_STATS_EN
    checks++;
    if (edge_count !== 16'(CLAMP_EDGES) || max_err !== 16'h7FFF) begin
      errors++;
      $display("FAIL clamp_stats: got edge_count=%0d max_err=%h expected %0d 7fff", edge_count, max_err, CLAMP_EDGES);
    end
`else
    checks++;
    if (edge_count !== 16'h0 || max_err !== 16'h0) begin
      errors++;
      $display("FAIL stats_tied: got edge_count=%h max_err=%h expected 0 0", edge_count, max_err);
    end
`endif
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_enable();
    test_track_edge();
    test_rate_change();
    test_lock();
    test_disable();
    test_reset_mid();
    test_clamp(16'h7FFF, 32'h0099999A, 1'b1);
    test_clamp(16'h8000, 32'h00AE147A, 1'b0);
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding edges expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
